// File: rtl/bitmap_row_scanner.sv
// ---------------------------------------------------------------------------
// bitmap_row_scanner
//   Streams a 1-bpp bitmap ROM out as RGB565 pixels in raster order.
//   The ROM is read one row at a time through a combinational row port.
//   Each row is captured into a shift register and then emitted over a
//   valid/ready handshake, with x/y coordinates and frame markers.
//
//   Optional build macro: BITMAP_MIRROR_EN
//     Adds the 'mirror' input. It is latched with start and held for the
//     frame. When it is latched high, each row is emitted right-to-left.
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active low
//   start       frame request, only looked at while idle
//   mirror      (BITMAP_MIRROR_EN only) emit rows right-to-left
//   rom_addr    registered row address to the bitmap ROM
//   rom_q       row data from the ROM, bit [IMG_W-1] is x=0
//   pix_valid   pixel available
//   pix_ready   downstream accepts the pixel
//   pix_data    RGB565 pixel
//   pix_x       column of the presented pixel, in emit order
//   pix_y       row of the presented pixel
//   pix_sof     high with pixel (0,0)
//   pix_eol     high with the last pixel of a row
//   busy        high whenever a frame is in progress
//   frame_done  one-cycle pulse after the last pixel is accepted
// ---------------------------------------------------------------------------
module bitmap_row_scanner #(
   parameter int unsigned IMG_W    = 128,
   parameter int unsigned IMG_H    = 128,
   parameter logic [15:0] FG_COLOR = 16'hFFFF,
   parameter logic [15:0] BG_COLOR = 16'h0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef BITMAP_MIRROR_EN
   input  logic             mirror,
`endif
   output logic [7:0]       rom_addr,
   input  logic [IMG_W-1:0] rom_q,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [15:0]      pix_data,
   output logic [6:0]       pix_x,
   output logic [6:0]       pix_y,
   output logic             pix_sof,
   output logic             pix_eol,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   localparam logic [6:0] LAST_X = 7'(IMG_W - 1);
   localparam logic [7:0] LAST_Y = 8'(IMG_H - 1);

   logic [1:0]       state,      state_d;
   logic [IMG_W-1:0] shreg,      shreg_d;
   logic [7:0]       rom_addr_d;
   logic             pix_valid_d;
   logic [15:0]      pix_data_d;
   logic [6:0]       pix_x_d;
   logic [6:0]       pix_y_d;
   logic             pix_sof_d;
   logic             pix_eol_d;
   logic             busy_d;
   logic             frame_done_d;

   // Row direction for the current frame.
   logic             mir_q;
`ifdef BITMAP_MIRROR_EN
   logic             mir_d;
`endif

   logic             first_bit_c;
   logic             next_bit_c;
   logic [IMG_W-1:0] shifted_c;
   logic             transfer_c;
   logic             last_x_c;
   logic             last_y_c;

   // Pixel selection: MSB-first normally, LSB-first when mirrored.
   always_comb begin
      first_bit_c = mir_q ? rom_q[0] : rom_q[IMG_W-1];
      next_bit_c  = mir_q ? shreg[1] : shreg[IMG_W-2];
      shifted_c   = mir_q ? (shreg >> 1) : (shreg << 1);
   end

   assign transfer_c = pix_valid & pix_ready;
   assign last_x_c   = (pix_x == LAST_X);
   assign last_y_c   = (rom_addr == LAST_Y);

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state;
      shreg_d      = shreg;
      rom_addr_d   = rom_addr;
      pix_valid_d  = pix_valid;
      pix_data_d   = pix_data;
      pix_x_d      = pix_x;
      pix_y_d      = pix_y;
      pix_sof_d    = pix_sof;
      pix_eol_d    = pix_eol;
      frame_done_d = 1'b0;
`ifdef BITMAP_MIRROR_EN
      mir_d        = mir_q;
`endif

      case (state)
         ST_IDLE: begin
            if (start) begin
               rom_addr_d = 8'd0;
               state_d    = ST_FETCH;
`ifdef BITMAP_MIRROR_EN
               mir_d      = mirror;
`endif
            end
         end

         // rom_addr has been stable for a full cycle, so rom_q is valid here.
         ST_FETCH: begin
            shreg_d     = rom_q;
            pix_valid_d = 1'b1;
            pix_data_d  = first_bit_c ? FG_COLOR : BG_COLOR;
            pix_x_d     = 7'd0;
            pix_y_d     = 7'(rom_addr);
            pix_sof_d   = (rom_addr == 8'd0);
            pix_eol_d   = (LAST_X == 7'd0);
            state_d     = ST_STREAM;
         end

         ST_STREAM: begin
            if (transfer_c) begin
               if (!last_x_c) begin
                  // Next pixel of the same row, no bubble.
                  shreg_d    = shifted_c;
                  pix_data_d = next_bit_c ? FG_COLOR : BG_COLOR;
                  pix_x_d    = 7'(pix_x + 7'd1);
                  pix_sof_d  = 1'b0;
                  pix_eol_d  = (7'(pix_x + 7'd1) == LAST_X);
               end else begin
                  pix_valid_d = 1'b0;
                  pix_sof_d   = 1'b0;
                  pix_eol_d   = 1'b0;
                  if (last_y_c) begin
                     frame_done_d = 1'b1;
                     state_d      = ST_IDLE;
                  end else begin
                     // Single bubble cycle while the next row is fetched.
                     rom_addr_d = 8'(rom_addr + 8'd1);
                     state_d    = ST_FETCH;
                  end
               end
            end
         end

         default: begin
            state_d     = ST_IDLE;
            pix_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         rom_addr   <= 8'd0;
         pix_valid  <= 1'b0;
         pix_data   <= BG_COLOR;
         pix_x      <= 7'd0;
         pix_y      <= 7'd0;
         pix_sof    <= 1'b0;
         pix_eol    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         shreg      <= shreg_d;
         rom_addr   <= rom_addr_d;
         pix_valid  <= pix_valid_d;
         pix_data   <= pix_data_d;
         pix_x      <= pix_x_d;
         pix_y      <= pix_y_d;
         pix_sof    <= pix_sof_d;
         pix_eol    <= pix_eol_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
      end
   end

`ifdef BITMAP_MIRROR_EN
   // Mirror flag, latched with start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mir_q <= 1'b0;
      end else begin
         mir_q <= mir_d;
      end
   end
`else
   assign mir_q = 1'b0;
`endif

endmodule

// File: tb/tb_bitmap_row_scanner.sv
// ---------------------------------------------------------------------------
// tb_bitmap_row_scanner
//   Directed bench for bitmap_row_scanner with a small behavioural ROM.
// ---------------------------------------------------------------------------
module tb_bitmap_row_scanner;

   localparam int unsigned W = 128;
   localparam int unsigned H = 128;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         pix_ready = 1'b0;
   logic [7:0]   rom_addr;
   logic [W-1:0] rom_q;
   logic         pix_valid;
   logic [15:0]  pix_data;
   logic [6:0]   pix_x;
   logic [6:0]   pix_y;
   logic         pix_sof;
   logic         pix_eol;
   logic         busy;
   logic         frame_done;
`ifdef BITMAP_MIRROR_EN
   logic         mirror = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Results of the last run_frame call.
   int          r_npix, r_bad, r_eols, r_done_t, r_stall_bad, r_addr_bad, r_first_t;
   logic        r_first_sof;
   logic [15:0] r_first_data, r_px_3_55;
   logic [15:0] r_px16 [0:2];
   logic [6:0]  r_abort_x, r_abort_y;

   always #5 clk = ~clk;

   // Behavioural ROM: row 0 blank, rows 3 and 16 hand-picked, rest hashed.
   function automatic logic [W-1:0] rom_row(input logic [7:0] a);
      logic [31:0] w;
      if (a >= 8'(H)) return {4{32'hDEADBEEF}};
      case (a)
         8'd0:    return '0;
         8'd3:    return 128'h0000_0000_0000_0100_0000_0000_0000_0000;
         8'd16:   return 128'h8000_0000_0000_0000_0000_0000_0000_0003;
         default: begin
            w = {a, a ^ 8'h3C, 8'(a * 8'd7), ~a};
            return {w, ~w, w ^ 32'h5A5A_A5A5, {w[15:0], w[31:16]}};
         end
      endcase
   endfunction

   assign rom_q = rom_row(rom_addr);

   bitmap_row_scanner dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
`ifdef BITMAP_MIRROR_EN
      .mirror     (mirror),
`endif
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_sof    (pix_sof),
      .pix_eol    (pix_eol),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Starts a frame and consumes it against the ROM model. t=0 is FETCH entry.
   // start_at: pixel index at which start is re-asserted (-1 none).
   // abort_at: pixel index at which rst_n is pulled low (-1 none).
   task automatic run_frame(input int ready_pct, input bit mir, input int start_at,
                            input int abort_at);
      int          ex, ey, t;
      bit          held;
      logic [15:0] hd, exp_d;
      logic [6:0]  hx, hy;
      logic        hs, he;
      logic [W-1:0] row;
      r_npix = 0; r_bad = 0; r_eols = 0; r_done_t = -1; r_stall_bad = 0;
      r_addr_bad = 0; r_first_t = -1; r_first_sof = 1'b0; r_first_data = 16'hxxxx;
      r_px_3_55 = 16'hxxxx;
      for (int i = 0; i < 3; i++) r_px16[i] = 16'hxxxx;
      held = 1'b0; hd = '0; hx = '0; hy = '0; hs = 1'b0; he = 1'b0;
`ifdef BITMAP_MIRROR_EN
      mirror = mir;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0; ex = 0; ey = 0;
      while (t < 40000) begin
         if (rom_addr > 8'(H - 1)) r_addr_bad++;
         if (held) begin
            if (pix_valid !== 1'b1 || pix_data !== hd || pix_x !== hx || pix_y !== hy ||
                pix_sof !== hs || pix_eol !== he) r_stall_bad++;
         end
         held = 1'b0;
         if (pix_valid === 1'b1 && r_first_t < 0) begin
            r_first_t = t; r_first_sof = pix_sof; r_first_data = pix_data;
         end
         if (abort_at >= 0 && r_npix == abort_at && pix_valid === 1'b1) begin
            r_abort_x = pix_x; r_abort_y = pix_y;
            rst_n = 1'b0; pix_ready = 1'b0;
            @(posedge clk); #1;
            return;
         end
         pix_ready = (int'($urandom_range(99, 0)) < ready_pct);
         start = (start_at >= 0 && r_npix == start_at);
         if (pix_valid === 1'b1 && pix_ready) begin
            row   = rom_row(8'(ey));
            exp_d = (mir ? row[ex] : row[W - 1 - ex]) ? 16'hFFFF : 16'h0000;
            if (pix_x !== 7'(ex) || pix_y !== 7'(ey) || pix_data !== exp_d ||
                pix_sof !== (ex == 0 && ey == 0) || pix_eol !== (ex == W - 1)) r_bad++;
            if (ey == 3 && ex == 55) r_px_3_55 = pix_data;
            if (ey == 16 && ex < 3) r_px16[ex] = pix_data;
            if (pix_eol === 1'b1) r_eols++;
            r_npix++;
            ex++;
            if (ex == W) begin ex = 0; ey++; end
         end else if (pix_valid === 1'b1) begin
            held = 1'b1; hd = pix_data; hx = pix_x; hy = pix_y; hs = pix_sof; he = pix_eol;
         end
         @(posedge clk); #1;
         t++;
         if (frame_done === 1'b1) begin
            r_done_t = t;
            start = 1'b0;
            return;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr got %h exp 00", rom_addr); end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %b exp 0", pix_valid); end
      checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL reset_pix_data got %h exp 0000", pix_data); end
      checks++; if (pix_x !== 7'd0 || pix_y !== 7'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d exp 0,0", pix_x, pix_y); end
      checks++; if (pix_sof !== 1'b0 || pix_eol !== 1'b0) begin errors++; $display("FAIL reset_sof_eol got %b%b exp 00", pix_sof, pix_eol); end
      checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, frame_done); end
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || rom_addr !== 8'd0 || pix_valid !== 1'b0) begin
         errors++; $display("FAIL idle_hold got busy=%b addr=%h valid=%b exp 0,00,0", busy, rom_addr, pix_valid); end
   endtask

   task automatic test_full_frame();
      run_frame(100, 1'b0, -1, -1);
      checks++; if (r_first_t !== 1) begin errors++; $display("FAIL ff_first_latency got %0d exp 1", r_first_t); end
      checks++; if (r_first_sof !== 1'b1) begin errors++; $display("FAIL ff_first_sof got %b exp 1", r_first_sof); end
      checks++; if (r_first_data !== 16'h0000) begin errors++; $display("FAIL ff_first_data got %h exp 0000", r_first_data); end
      checks++; if (r_px_3_55 !== 16'hFFFF) begin errors++; $display("FAIL ff_row3_x55 got %h exp FFFF", r_px_3_55); end
      checks++; if (r_px16[0] !== 16'hFFFF || r_px16[1] !== 16'h0000 || r_px16[2] !== 16'h0000) begin
         errors++; $display("FAIL ff_row16 got %h %h %h exp FFFF 0000 0000", r_px16[0], r_px16[1], r_px16[2]); end
      checks++; if (r_done_t !== 16512) begin errors++; $display("FAIL ff_done_cycle got %0d exp 16512", r_done_t); end
      checks++; if (r_npix !== 16384) begin errors++; $display("FAIL ff_pixels got %0d exp 16384", r_npix); end
      checks++; if (r_bad !== 0) begin errors++; $display("FAIL ff_pixel_seq got %0d bad exp 0", r_bad); end
      checks++; if (r_eols !== 128) begin errors++; $display("FAIL ff_eol_count got %0d exp 128", r_eols); end
      checks++; if (r_addr_bad !== 0) begin errors++; $display("FAIL ff_addr_range got %0d exp 0", r_addr_bad); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ff_idle_at_done got busy=%b exp 0", busy); end
   endtask

   // Entered in the frame_done cycle left by test_full_frame.
   task automatic test_back_to_back();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %b exp 0", frame_done); end
      checks++; if (busy !== 1'b1 || rom_addr !== 8'd0 || pix_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_fetch got busy=%b addr=%h valid=%b exp 1,00,0", busy, rom_addr, pix_valid); end
      @(posedge clk); #1;
      checks++; if (pix_valid !== 1'b1 || pix_sof !== 1'b1 || pix_x !== 7'd0 || pix_y !== 7'd0) begin
         errors++; $display("FAIL b2b_first_pix got v=%b sof=%b x=%0d y=%0d exp 1,1,0,0", pix_valid, pix_sof, pix_x, pix_y); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_backpressure();
      run_frame(70, 1'b0, 1000, -1);
      checks++; if (r_done_t < 0) begin errors++; $display("FAIL bp_timeout got no frame_done exp frame_done"); end
      checks++; if (r_npix !== 16384) begin errors++; $display("FAIL bp_pixels got %0d exp 16384", r_npix); end
      checks++; if (r_bad !== 0) begin errors++; $display("FAIL bp_pixel_seq got %0d bad exp 0", r_bad); end
      checks++; if (r_stall_bad !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d bad exp 0", r_stall_bad); end
      checks++; if (r_eols !== 128) begin errors++; $display("FAIL bp_eol_count got %0d exp 128", r_eols); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin
         errors++; $display("FAIL bp_start_not_queued got busy=%b valid=%b exp 0,0", busy, pix_valid); end
   endtask

   task automatic test_reset_mid_frame();
      bit mir;
      bit done_seen;
`ifdef BITMAP_MIRROR_EN
      mir = 1'b1;
`else
      mir = 1'b0;
`endif
      run_frame(100, 1'b0, -1, 40 * 128 + 17);
      checks++; if (r_abort_x !== 7'd17 || r_abort_y !== 7'd40) begin
         errors++; $display("FAIL rst_point got %0d,%0d exp 17,40", r_abort_x, r_abort_y); end
      checks++; if (pix_valid !== 1'b0 || rom_addr !== 8'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         errors++; $display("FAIL rst_mid got v=%b addr=%h busy=%b done=%b exp 0,00,0,0", pix_valid, rom_addr, busy, frame_done); end
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (frame_done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
      end
      checks++; if (done_seen) begin errors++; $display("FAIL rst_no_done got activity exp idle"); end
      run_frame(100, mir, -1, -1);
      checks++; if (r_done_t !== 16512 || r_npix !== 16384) begin
         errors++; $display("FAIL rst_refill got done=%0d pix=%0d exp 16512,16384", r_done_t, r_npix); end
      checks++; if (r_bad !== 0 || r_first_sof !== 1'b1) begin
         errors++; $display("FAIL rst_refill_seq got bad=%0d sof=%b exp 0,1", r_bad, r_first_sof); end
`ifdef BITMAP_MIRROR_EN
      checks++; if (r_px16[0] !== 16'hFFFF || r_px16[1] !== 16'hFFFF || r_px16[2] !== 16'h0000) begin
         errors++; $display("FAIL mirror_row16 got %h %h %h exp FFFF FFFF 0000", r_px16[0], r_px16[1], r_px16[2]); end
`endif
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
